// File: rtl/dc_bsp_pkg.sv
// dc_bsp_pkg: shared shim stream widths, arbiter defaults and arbiter state encoding
package dc_bsp_pkg;
  localparam int SHIM_AVST_DATA_WIDTH = 32;
  localparam int SHIM_ARB_MAX_BURST_DEFAULT = 16;
  typedef enum logic {IDLE, BURST} arb_state_e;
endpackage

// File: rtl/shim_avst_skid.sv
// shim_avst_skid: 2-entry registered skid buffer, FIFO order, registered in_ready
module shim_avst_skid
  import dc_bsp_pkg::*;
#(
  parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic [1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic rdy_q, push, pop;
  always_comb begin
    push = in_valid & rdy_q;
    pop = out_ready & (cnt_q != 2'd0);
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    e0_d = (cnt_q == 2'd2 && pop) ? e1_q : (push && (cnt_q == 2'd0 || pop)) ? in_data : e0_q;
    e1_d = (push && cnt_q == 2'd1 && !pop) ? in_data : e1_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_data = e0_q;
endmodule

// File: rtl/shim_avst_rr_arb.sv
// shim_avst_rr_arb: round-robin burst arbiter sharing one shim AVST sink among NUM_REQ sources
module shim_avst_rr_arb
  import dc_bsp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH,
  parameter int MAX_BURST = SHIM_ARB_MAX_BURST_DEFAULT,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 src_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] src_data,
  output logic [NUM_REQ-1:0]                 src_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  output logic                               grant_valid,
  output logic [IW-1:0]                      grant_idx
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, gidx_q, gidx_d, sel, owner;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW:0] pick;
  logic any, acc, skid_rdy;
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] last);
    logic [IW:0] r;
    int idx;
    r = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (v[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction
  always_comb begin
    pick = rr_pick(src_valid, last_q);
    any = pick[IW];
    sel = pick[IW-1:0];
    owner = (state_q == BURST) ? gidx_q : sel;
    src_ready = ((state_q == BURST || any) && skid_rdy) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0;
    acc = |(src_valid & src_ready);
    state_d = state_q;
    last_d = last_q;
    gidx_d = gidx_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (acc) begin
        state_d = (MAX_BURST > 1) ? BURST : IDLE;
        last_d = sel;
        gidx_d = sel;
        cnt_d = CW'(1);
      end
    end else if (!src_valid[gidx_q]) state_d = IDLE;
    else if (acc) begin
      if (cnt_q == CW'(MAX_BURST - 1)) state_d = IDLE;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      gidx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gidx_q <= gidx_d;
      cnt_q <= cnt_d;
    end
  end
  shim_avst_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(acc),
    .in_ready(skid_rdy),
    .in_data(src_data[owner]),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
  assign grant_valid = state_q == BURST;
  assign grant_idx = gidx_q;
endmodule

// File: tb/tb_shim_avst_rr_arb.sv
// tb_shim_avst_rr_arb: reference-model scoreboard bench for the round-robin burst arbiter
module tb_shim_avst_rr_arb;
  localparam int N = 4;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0][31:0] src_data = '0;
  logic [N-1:0] src_ready;
  logic out_valid, out_ready = 1'b0, grant_valid;
  logic [31:0] out_data;
  logic [1:0] grant_idx;
  int n_err = 0, n_chk = 0;
  logic [31:0] q[$];
  logic [23:0] seq[N];
  int m_state, m_last, m_gidx, m_cnt, m_skcnt, m_inrdy;

  shim_avst_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = N - 1; m_gidx = 0; m_cnt = 0; m_skcnt = 0; m_inrdy = 0;
    q.delete();
  endtask

  task automatic step(input logic [N-1:0] v, input logic ordy);
    logic [N-1:0] m_rdy;
    int sel, own;
    bit found, acc, pop;
    src_valid = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) src_data[i] = {8'(i), seq[i]};
    found = 0;
    sel = 0;
    for (int k = 1; k <= N; k++)
      if (!found && v[(m_last + k) % N]) begin found = 1; sel = (m_last + k) % N; end
    own = (m_state == 1) ? m_gidx : sel;
    m_rdy = ((m_state == 1 || found) && m_inrdy != 0) ? (4'b0001 << own) : 4'b0000;
    #1;
    check("src_ready", src_ready, m_rdy);
    check("out_valid", out_valid, m_skcnt != 0);
    check("grant_valid", grant_valid, m_state == 1);
    check("grant_idx", grant_idx, m_gidx);
    if (out_valid && ordy) begin
      if (q.size() == 0) check("unexpected_beat", out_data, 0);
      else check("out_data", out_data, q.pop_front());
    end
    acc = (v & m_rdy) != 0;
    pop = ordy && m_skcnt != 0;
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back({8'(own), seq[own]});
      seq[own]++;
    end
    if (m_state == 0) begin
      if (acc) begin m_state = 1; m_last = sel; m_gidx = sel; m_cnt = 1; end
    end else if (!v[m_gidx]) m_state = 0;
    else if (acc) begin
      if (m_cnt == MB - 1) m_state = 0;
      else m_cnt++;
    end
    m_skcnt = m_skcnt + int'(acc) - int'(pop);
    m_inrdy = (m_skcnt <= 1) ? 1 : 0;
  endtask

  initial begin
    int guard;
    logic [23:0] start;
    for (int i = 0; i < N; i++) seq[i] = 24'(i * 24'h1000);
    model_reset();
    src_valid = 4'b1111;
    repeat (5) begin
      @(negedge clk);
      check("rst_src_ready", src_ready, 0);
      check("rst_out_valid", out_valid, 0);
    end
    reset_n = 1'b1;
    step(4'b1111, 1);
    #1 check("first_grant", src_ready, 4'b0001);
    repeat (70) step(4'b1111, 1);
    repeat (50) step(4'b0101, 1);
    repeat (6) step(4'b0000, 1);
    check("drain_q", q.size(), 0);
    guard = 0;
    start = seq[1];
    while (seq[1] - start < 3 && guard < 50) begin step(4'b0010, 1); guard++; end
    check("rel_timeout", guard < 50, 1);
    step(4'b1000, 1);
    check("rel_bubble_gv", grant_valid, 0);
    step(4'b1000, 1);
    check("rel_grant_idx", grant_idx, 3);
    repeat (5) step(4'b1000, 1);
    repeat (4) step(4'b0001, 1);
    repeat (10) step(4'b0001, 0);
    check("bp_buffered", q.size(), 2);
    #1 check("bp_ready_low", src_ready, 0);
    repeat (30) step(4'b0001, 1);
    repeat (300) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    repeat (6) step(4'b0000, 1);
    check("drain_q2", q.size(), 0);
    guard = 0;
    start = seq[2];
    while (seq[2] - start < 5 && guard < 50) begin step(4'b0100, 1); guard++; end
    check("mid_timeout", guard < 50, 1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_grant_valid", grant_valid, 0);
    check("mid_src_ready", src_ready, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1111, 1);
    #1 check("restart_grant", src_ready, 4'b0001);
    repeat (40) step(4'b1111, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
